i2c_bit_engine: RTL

- Bit/byte-level I2C master engine: executes START, WRITE-byte, READ-byte and STOP commands on an open-drain SCL/SDA pair.
- Paced by the 400kHz strobe from the clock/reset generator. Four strobes make one SCL bit, so SCL runs at 100kHz.
- Sits between that generator and the camera-init sequencer. The sequencer issues one command at a time and collects the result.

---
 rtl/i2c_bit_engine_pkg.sv | 38 +++
 rtl/i2c_bit_engine_shift_reg.sv | 41 ++++
 rtl/i2c_bit_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bit_engine_pkg.sv
// Shared types and constants for the I2C master bit engine.
// Covers the command encoding, the FSM state encoding and the per-byte bit/phase geometry.
package i2c_bit_engine_pkg;

  localparam int unsigned I2C_PHASES_PER_BIT = 4;
  localparam int unsigned I2C_BITS_PER_XFER  = 9;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_STOP  = 3'd4
  } i2c_state_t;

  // Only START may be issued while the bus is not owned.
  function automatic logic cmd_is_legal(input i2c_cmd_t c, input logic owned);
    return (c == CMD_START) || owned;
  endfunction

  function automatic i2c_state_t cmd_to_state(input i2c_cmd_t c);
    case (c)
      CMD_START: return ST_START;
      CMD_WRITE: return ST_WRITE;
      CMD_READ:  return ST_READ;
      CMD_STOP:  return ST_STOP;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bit_engine_shift_reg.sv
// 8-bit MSB-first shift register with parallel load.
// WRITE serialises from bit 7; READ shifts the sampled SDA in at bit 0.
module i2c_shift_reg (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic       shift_i,
  input  logic       serial_i,
  output logic       serial_o,
  output logic [7:0] data_o
);

  logic [7:0] data_q;
  logic [7:0] data_d;

  // Next-state: load has priority over shift.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {data_q[6:0], serial_i};
    end else begin
      data_d = data_q;
    end
  end

  // Shift register state.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_d;
    end
  end

  assign serial_o = data_q[7];
  assign data_o   = data_q;

endmodule

// File: rtl/i2c_bit_engine.sv
// I2C master bit engine: runs START / WRITE / READ / STOP on open-drain SCL/SDA,
// advancing one phase per 400kHz strobe (four phases per SCL bit).
module i2c_bit_engine
  import i2c_bit_engine_pkg::*;
#(
  parameter int unsigned PHASES_PER_BIT = I2C_PHASES_PER_BIT
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       strobe_400khz,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ack_err,
  output logic       bus_owned,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam logic [1:0] LAST_PHASE = 2'(PHASES_PER_BIT - 1);
  localparam logic [3:0] ACK_BIT    = 4'(I2C_BITS_PER_XFER - 1);

  i2c_state_t state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] bit_q, bit_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;
  logic       bus_owned_q, bus_owned_d;
  logic       ready_q, ready_d;
  logic [7:0] rdata_q, rdata_d;
  logic       nack_q, nack_d;

  logic       sr_load, sr_shift, sr_serial;
  logic [7:0] sr_load_data, sr_data;
  i2c_cmd_t   cmd_e;
  logic       is_data, stall, step;

  assign cmd_e   = i2c_cmd_t'(cmd);
  assign is_data = (state_q == ST_WRITE) || (state_q == ST_READ);
  // Strobes ending ph1/ph2 wait while a slave holds SCL low.
  assign stall   = is_data && phase_q[1] && !scl_in;
  assign step    = strobe_400khz && !stall;

  i2c_shift_reg u_shift (
    .clk         (clk),
    .areset_n    (areset_n),
    .load_i      (sr_load),
    .load_data_i (sr_load_data),
    .shift_i     (sr_shift),
    .serial_i    (sda_in),
    .serial_o    (sr_serial),
    .data_o      (sr_data)
  );

  // Command FSM: phase_q names the phase whose actions the next usable strobe applies.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    scl_oe_d     = scl_oe_q;
    sda_oe_d     = sda_oe_q;
    done_d       = 1'b0;
    ack_err_d    = ack_err_q;
    bus_owned_d  = bus_owned_q;
    ready_d      = ready_q | done_q;
    rdata_d      = rdata_q;
    nack_d       = nack_q;
    sr_load      = 1'b0;
    sr_load_data = 8'h00;
    sr_shift     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          ready_d      = 1'b0;
          phase_d      = 2'd0;
          bit_d        = 4'd0;
          nack_d       = cmd_nack;
          sr_load      = 1'b1;
          sr_load_data = (cmd_e == CMD_WRITE) ? cmd_wdata : 8'h00;
          if (cmd_is_legal(cmd_e, bus_owned_q)) begin
            state_d = cmd_to_state(cmd_e);
          end else begin
            done_d    = 1'b1;
            ack_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START, ST_STOP: begin
        if (strobe_400khz) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: begin
              scl_oe_d = (state_q == ST_STOP);
              sda_oe_d = (state_q == ST_STOP);
            end
            2'd1: begin
              if (state_q == ST_START) sda_oe_d = 1'b1;
              else                     scl_oe_d = 1'b0;
            end
            2'd2: begin
              if (state_q == ST_START) scl_oe_d = 1'b1;
              else                     sda_oe_d = 1'b0;
            end
            default: begin
              done_d      = 1'b1;
              ack_err_d   = 1'b0;
              bus_owned_d = (state_q == ST_START);
              state_d     = ST_IDLE;
            end
          endcase
        end else begin
          phase_d = phase_q;
        end
      end
      ST_WRITE, ST_READ: begin
        if (step) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: begin
              scl_oe_d = 1'b1;
              if (bit_q == ACK_BIT) sda_oe_d = (state_q == ST_READ) && !nack_q;
              else                  sda_oe_d = (state_q == ST_WRITE) && !sr_serial;
            end
            2'd1: begin
              scl_oe_d = 1'b0;
            end
            2'd2: begin
              scl_oe_d = 1'b0;
            end
            default: begin
              scl_oe_d = 1'b1;
              if (phase_q == LAST_PHASE && bit_q == ACK_BIT) begin
                done_d    = 1'b1;
                ack_err_d = (state_q == ST_WRITE) && sda_in;
                if (state_q == ST_READ) rdata_d = sr_data;
                state_d   = ST_IDLE;
              end else begin
                sr_shift = 1'b1;
                bit_d    = bit_q + 4'd1;
              end
            end
          endcase
        end else begin
          phase_d = phase_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Engine state and registered outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      bit_q       <= 4'd0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      bus_owned_q <= 1'b0;
      ready_q     <= 1'b1;
      rdata_q     <= 8'h00;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      bus_owned_q <= bus_owned_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      nack_q      <= nack_d;
    end
  end

  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign ack_err   = ack_err_q;
  assign bus_owned = bus_owned_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule
